// File: rtl/inputbuffer_array_if.sv
// Link-side and arbiter-side signal bundle for the per-port input FIFO bank.
// The router (slave) receives pushes and pop requests; the master drives them.
interface inputbuffer_array_if #(
    parameter int NUM_PORTS = 5,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 3
);
    logic [NUM_PORTS-1:0]        valid_i;
    logic [NUM_PORTS*DATA_W-1:0] data_i;
    logic [NUM_PORTS-1:0]        pop_req_i;
    logic [NUM_PORTS*DATA_W-1:0] data_o;
    logic [NUM_PORTS-1:0]        en_o;
    logic [NUM_PORTS-1:0]        full_o;
    logic [NUM_PORTS*CNT_W-1:0]  count_o;
    logic [NUM_PORTS-1:0]        credit_o;
    logic [NUM_PORTS-1:0]        ovf_o;

    modport master (
        output valid_i, data_i, pop_req_i,
        input  data_o, en_o, full_o, count_o, credit_o, ovf_o
    );

    modport slave (
        input  valid_i, data_i, pop_req_i,
        output data_o, en_o, full_o, count_o, credit_o, ovf_o
    );
endinterface

// File: rtl/inputbuffer_array.sv
// Bank of independent show-ahead circular FIFOs, one per router input port,
// with occupancy count, registered credit return and sticky overflow flag.
module inputbuffer_array #(
    parameter int NUM_PORTS = 5,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    inputbuffer_array_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [NUM_PORTS*DATA_W-1:0] data_s;
    logic [NUM_PORTS*CNT_W-1:0]  count_s;
    logic [NUM_PORTS-1:0]        en_s;
    logic [NUM_PORTS-1:0]        full_s;
    logic [NUM_PORTS-1:0]        credit_s;
    logic [NUM_PORTS-1:0]        ovf_s;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [DATA_W-1:0] mem_r [DEPTH];
        logic [PTR_W-1:0]  wr_ptr_r;
        logic [PTR_W-1:0]  rd_ptr_r;
        logic [CNT_W-1:0]  cnt_r;
        logic              credit_r;
        logic              ovf_r;
        logic              pop_s;
        logic              push_s;
        logic              drop_s;

        // A full queue still accepts a push when a pop frees the head slot in the same cycle.
        always_comb begin
            pop_s  = bus.pop_req_i[p] && (cnt_r != CNT_ZERO);
            push_s = bus.valid_i[p] && ((cnt_r != CNT_FULL) || pop_s);
            drop_s = bus.valid_i[p] && !push_s;
        end

        // Queue storage, pointers, occupancy, credit pulse and overflow flag.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_r[i] <= {DATA_W{1'b0}};
                end
                wr_ptr_r <= PTR_ZERO;
                rd_ptr_r <= PTR_ZERO;
                cnt_r    <= CNT_ZERO;
                credit_r <= 1'b0;
                ovf_r    <= 1'b0;
            end else begin
                if (push_s) begin
                    mem_r[wr_ptr_r] <= bus.data_i[p*DATA_W +: DATA_W];
                    wr_ptr_r        <= wr_ptr_r + PTR_ONE;
                end else begin
                    wr_ptr_r        <= wr_ptr_r;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end else begin
                    rd_ptr_r <= rd_ptr_r;
                end
                case ({push_s, pop_s})
                    2'b10:   cnt_r <= cnt_r + CNT_ONE;
                    2'b01:   cnt_r <= cnt_r - CNT_ONE;
                    default: cnt_r <= cnt_r;
                endcase
                credit_r <= pop_s;
                ovf_r    <= ovf_r | drop_s;
            end
        end

        assign data_s[p*DATA_W +: DATA_W] = mem_r[rd_ptr_r];
        assign count_s[p*CNT_W +: CNT_W]  = cnt_r;
        assign en_s[p]                    = (cnt_r != CNT_ZERO);
        assign full_s[p]                  = (cnt_r == CNT_FULL);
        assign credit_s[p]                = credit_r;
        assign ovf_s[p]                   = ovf_r;
    end

    assign bus.data_o   = data_s;
    assign bus.count_o  = count_s;
    assign bus.en_o     = en_s;
    assign bus.full_o   = full_s;
    assign bus.credit_o = credit_s;
    assign bus.ovf_o    = ovf_s;
endmodule

// File: tb/tb_inputbuffer_array.sv
// Directed bench for inputbuffer_array: reset, fill/drain, full push+pop with wrap,
// empty corner cases, multi-port isolation with a queue model, mid-operation reset.
module tb_inputbuffer_array;
    localparam int NP = 5;
    localparam int DW = 32;
    localparam int DP = 4;
    localparam int CW = 3;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    inputbuffer_array_if #(.NUM_PORTS(NP), .DATA_W(DW), .CNT_W(CW)) bus ();

    inputbuffer_array #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DP), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] cnt_of(input int p);
        return bus.count_o[p*CW +: CW];
    endfunction

    function automatic logic [DW-1:0] dat_of(input int p);
        return bus.data_o[p*DW +: DW];
    endfunction

    task automatic idle();
        bus.valid_i   = '0;
        bus.pop_req_i = '0;
        bus.data_i    = '0;
    endtask

    task automatic push(input int p, input logic [DW-1:0] d);
        bus.valid_i[p]         = 1'b1;
        bus.data_i[p*DW +: DW] = d;
    endtask

    logic [DW-1:0] sb [NP][$];
    logic [DW-1:0] dv [NP];
    logic [NP-1:0] vv;
    logic [NP-1:0] pv;
    logic [NP-1:0] ovf_exp;
    int            cred_obs;
    int            cred_exp;
    int            seq;

    initial begin
        checks   = 0;
        failures = 0;
        cred_obs = 0;
        cred_exp = 0;
        seq      = 0;
        idle();

        // Reset with random activity on the inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.valid_i   = NP'($urandom);
            bus.pop_req_i = NP'($urandom);
            bus.data_i    = {$urandom, $urandom, $urandom, $urandom, $urandom};
            step();
        end
        rst = 1'b0;
        idle();
        check("rst_count", 64'(bus.count_o), 64'h0);
        check("rst_en", 64'(bus.en_o), 64'h0);
        check("rst_full", 64'(bus.full_o), 64'h0);
        check("rst_credit", 64'(bus.credit_o), 64'h0);
        check("rst_ovf", 64'(bus.ovf_o), 64'h0);
        check("rst_data_lo", bus.data_o[63:0], 64'h0);
        check("rst_data_hi", 64'(bus.data_o[159:64]), 64'h0);

        // Fill port 2, then a dropped fifth push
        for (int i = 0; i < 4; i++) begin
            idle();
            push(2, 32'hA0 + 32'(i));
            step();
            check("fill_cnt", 64'(cnt_of(2)), 64'(i + 1));
            check("fill_full", 64'(bus.full_o[2]), (i == 3) ? 64'h1 : 64'h0);
        end
        idle();
        push(2, 32'hA4);
        step();
        idle();
        check("drop_ovf", 64'(bus.ovf_o[2]), 64'h1);
        check("drop_cnt", 64'(cnt_of(2)), 64'h4);
        check("drop_other_ovf", 64'(bus.ovf_o & 5'b11011), 64'h0);
        for (int i = 0; i < 4; i++) begin
            check("drain_data", 64'(dat_of(2)), 64'h0A0 + 64'(i));
            bus.pop_req_i[2] = 1'b1;
            step();
            check("drain_credit", 64'(bus.credit_o[2]), 64'h1);
            check("drain_cnt", 64'(cnt_of(2)), 64'(3 - i));
        end
        idle();
        step();
        check("drain_credit_end", 64'(bus.credit_o[2]), 64'h0);
        check("drain_en", 64'(bus.en_o[2]), 64'h0);
        check("drain_ovf_sticky", 64'(bus.ovf_o[2]), 64'h1);

        // Port 0 full, simultaneous push and pop, then three laps of wrap
        for (int i = 0; i < 4; i++) begin
            idle();
            push(0, 32'h10 + 32'(i));
            step();
        end
        idle();
        check("p0_full", 64'(bus.full_o[0]), 64'h1);
        push(0, 32'h14);
        bus.pop_req_i[0] = 1'b1;
        step();
        check("fpp_cnt", 64'(cnt_of(0)), 64'h4);
        check("fpp_ovf", 64'(bus.ovf_o[0]), 64'h0);
        check("fpp_head", 64'(dat_of(0)), 64'h11);
        check("fpp_credit", 64'(bus.credit_o[0]), 64'h1);
        for (int i = 0; i < 12; i++) begin
            idle();
            push(0, 32'h15 + 32'(i));
            bus.pop_req_i[0] = 1'b1;
            step();
            check("wrap_head", 64'(dat_of(0)), 64'h12 + 64'(i));
            check("wrap_cnt", 64'(cnt_of(0)), 64'h4);
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            check("wrap_drain", 64'(dat_of(0)), 64'h1D + 64'(i));
            bus.pop_req_i[0] = 1'b1;
            step();
        end
        idle();
        check("wrap_empty", 64'(cnt_of(0)), 64'h0);
        check("wrap_ovf", 64'(bus.ovf_o[0]), 64'h0);

        // Empty-queue corner cases on port 1
        bus.pop_req_i[1] = 1'b1;
        step();
        check("empty_pop_credit", 64'(bus.credit_o[1]), 64'h0);
        check("empty_pop_cnt", 64'(cnt_of(1)), 64'h0);
        push(1, 32'h55);
        step();
        idle();
        check("nobypass_cnt", 64'(cnt_of(1)), 64'h1);
        check("nobypass_data", 64'(dat_of(1)), 64'h55);
        check("nobypass_credit", 64'(bus.credit_o[1]), 64'h0);
        bus.pop_req_i[1] = 1'b1;
        step();
        idle();
        check("p1_pop_credit", 64'(bus.credit_o[1]), 64'h1);
        check("p1_pop_cnt", 64'(cnt_of(1)), 64'h0);

        // Clean slate, then random traffic on all ports against a queue model
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_count", 64'(bus.count_o), 64'h0);
        check("rst2_ovf", 64'(bus.ovf_o), 64'h0);
        ovf_exp = '0;
        for (int c = 0; c < 60; c++) begin
            idle();
            vv = NP'($urandom);
            pv = NP'($urandom);
            for (int p = 0; p < NP; p++) begin
                dv[p] = (32'(p + 1) << 24) | 32'(seq);
                seq++;
                if (vv[p]) push(p, dv[p]);
                bus.pop_req_i[p] = pv[p];
            end
            step();
            for (int p = 0; p < NP; p++) begin
                logic pa;
                logic wa;
                pa = pv[p] && (sb[p].size() != 0);
                wa = vv[p] && ((sb[p].size() != DP) || pa);
                if (pa) void'(sb[p].pop_front());
                if (wa) sb[p].push_back(dv[p]);
                if (vv[p] && !wa) ovf_exp[p] = 1'b1;
                cred_exp += int'(pa);
                cred_obs += int'(bus.credit_o[p]);
                check("iso_cnt", 64'(cnt_of(p)), 64'(sb[p].size()));
                check("iso_credit", 64'(bus.credit_o[p]), 64'(pa));
                check("iso_ovf", 64'(bus.ovf_o[p]), 64'(ovf_exp[p]));
                if (sb[p].size() != 0) check("iso_data", 64'(dat_of(p)), 64'(sb[p][0]));
            end
        end
        idle();
        check("iso_total_credits", 64'(cred_obs), 64'(cred_exp));

        // Mid-operation reset on port 3: three flits queued, pop requested in the reset cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            push(3, 32'h31 + 32'(i));
            step();
        end
        idle();
        check("mid_cnt_before", 64'(cnt_of(3)), 64'h3);
        bus.pop_req_i[3] = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        check("mid_credit0", 64'(bus.credit_o[3]), 64'h0);
        check("mid_cnt", 64'(cnt_of(3)), 64'h0);
        check("mid_data", 64'(dat_of(3)), 64'h0);
        step();
        check("mid_credit1", 64'(bus.credit_o), 64'h0);
        push(3, 32'h77);
        step();
        idle();
        check("mid_restart_cnt", 64'(cnt_of(3)), 64'h1);
        check("mid_restart_data", 64'(dat_of(3)), 64'h77);
        check("mid_restart_en", 64'(bus.en_o), 64'h08);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inputbuffer_array.md
# inputbuffer_array

Parametrised bank of per-port input FIFOs for the NoC router. It generalises the fixed five-port buffer stage to `NUM_PORTS` channels with configurable flit width and queue depth. It adds several behaviours to each queue: an occupancy count, a registered credit-return pulse for upstream flow control, and a sticky overflow flag. It sits between the link inputs and the router's arbiter/crossbar, which pops flits through `pop_req_i`.

## Interface
- `NUM_PORTS`, default 5: number of independent input channels (N, S, E, W, L ordering for the default router).
- `DATA_W`, default 32: flit width in bits.
- `DEPTH`, default 4: entries per queue; a power of two, at least 2.
- `CNT_W`, default `$clog2(DEPTH+1)`: width of each occupancy count field.

- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous reset, active-high.
- `valid_i`, input, `NUM_PORTS`: per-port push request; bit p belongs to port p.
- `data_i`, input, `NUM_PORTS*DATA_W`: flattened flits; port p uses bits [p*DATA_W +: DATA_W].
- `pop_req_i`, input, `NUM_PORTS`: per-port pop request from the arbiter.
- `data_o`, output, `NUM_PORTS*DATA_W`: head flit of each queue (show-ahead), same packing as `data_i`.
- `en_o`, output, `NUM_PORTS`: queue non-empty, meaning `data_o` for that port is valid.
- `full_o`, output, `NUM_PORTS`: queue holds `DEPTH` entries.
- `count_o`, output, `NUM_PORTS*CNT_W`: occupancy per port, 0..`DEPTH`.
- `credit_o`, output, `NUM_PORTS`: one-cycle pulse per flit popped; it is returned to the upstream sender.
- `ovf_o`, output, `NUM_PORTS`: sticky flag, set when a push is dropped; cleared only by `rst`.

## Operation
- Each port is an independent circular buffer with `DEPTH` entries, a write pointer, a read pointer and a count. Pointers are `$clog2(DEPTH)` bits and wrap naturally from `DEPTH-1` to 0.
- **Pop accepted:** `pop_req_i[p] && count != 0`.
  - The read pointer advances by 1.
  - A pop request on an empty queue is ignored: no state change and no credit.
- **Push accepted:** `valid_i[p] && (count != DEPTH || pop accepted)`.
  - The flit is written at the write pointer and the write pointer advances by 1.
  - A push and a pop in the same cycle on a full queue both succeed; the count stays at `DEPTH`.
- **Dropped push:** `valid_i[p]` while the queue is full and no pop is accepted.
  - The flit is discarded and the queue state is unchanged.
  - `ovf_o[p]` is set on the next edge.
- **Count update:** +1 for push only, −1 for pop only, unchanged for both or neither.
- **No bypass:** a push into an empty queue is not visible in the same cycle. A simultaneous pop request on that empty queue is ignored and the pushed flit is stored.
- **Outputs:**
  - `data_o` equals storage at the read pointer and is valid only when `en_o` is high. When the queue is empty its value is don't-care, but it must not be X after reset; storage resets to 0.
  - `en_o = count != 0`.
  - `full_o = count == DEPTH`.
  - `count_o` equals the count register.
- **Credits:** `credit_o[p]` is a registered copy of "pop accepted on port p". Upstream therefore initialises its credit counter to `DEPTH` per port.
- **Port independence:** ports share no state. Activity on one port never affects another.

## Timing
- Reset is synchronous. While `rst` is high at an edge:
  - All pointers and counts, `count_o`, `en_o`, `full_o`, `credit_o` and `ovf_o` go to 0.
  - Storage is cleared to 0.
  - Pushes and pops in that cycle are ignored and no credit is issued.
- Reset asserted mid-operation discards all queued flits. Any credit pulse due the following cycle is suppressed.
- **Push latency:** a push accepted at edge k gives `en_o` and `count_o` updates after edge k. The flit appears on `data_o` in cycle k+1 if the queue was empty, otherwise when it reaches the head.
- **Pop latency:** a pop accepted at edge k advances `data_o` to the next entry after edge k. `credit_o` is high for exactly the cycle following edge k.
- **Throughput:** one push and one pop per port per cycle, sustained indefinitely at any occupancy.
- `ovf_o` rises in the cycle after the dropped push and then stays high.

## Test plan
- **Reset:** assert `rst` for 2 cycles with random `valid_i`/`pop_req_i`. All outputs must be 0 and `count_o` must be 0 for every port.
- **Fill/drain, DEPTH=4, port 2:**
  - Push 0xA0..0xA3 on consecutive cycles. `count_o[2]` must step 1, 2, 3, 4 and `full_o[2]` must rise after the 4th push.
  - A 5th push of 0xA4 is dropped and `ovf_o[2]` sets.
  - Pop 4 times. `data_o` must read 0xA0, 0xA1, 0xA2, 0xA3 and `credit_o[2]` must pulse 4 times, each one cycle after its pop.
- **Full plus simultaneous push/pop:**
  - With port 0 full (0x10..0x13), push 0x14 while popping. The count must stay 4, `ovf_o[0]` must stay 0, and the head must become 0x11.
  - Wrap around 3 full laps. Order must be preserved.
- **Empty edge cases:**
  - Pop an empty queue: no credit and the count stays 0.
  - Push 0x55 and pop in the same cycle on an empty queue: the count becomes 1 and `data_o` equals 0x55 next cycle.
- **Port isolation:** run random traffic on all 5 ports at once with a per-port scoreboard. There must be no cross-port data and total credits must equal total accepted pops.
- **Mid-operation reset:** assert `rst` with 3 flits queued and a pop in flight. There must be no `credit_o` pulse afterwards, and new pushes must restart at count 1.
